// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: requester and function-block signals of the truth table sweeper
interface truth_table_sweeper_if #(parameter int N_IN = 4);
  logic start, abort, dut_f, busy, done, valid, pass, fail_valid;
  logic [N_IN-1:0] dut_in, first_fail;
  logic [2**N_IN-1:0] tt;
  logic [N_IN:0] mismatch_cnt;
  modport master(output start, abort, dut_f,
                 input dut_in, busy, done, tt, valid, pass, mismatch_cnt, first_fail, fail_valid);
  modport slave(input start, abort, dut_f,
                output dut_in, busy, done, tt, valid, pass, mismatch_cnt, first_fail, fail_valid);
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input vectors of a function block and checks its truth table
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int HOLD_CYCLES = 2,
  parameter logic [2**N_IN-1:0] EXP_TT = '0
) (
  input logic clk,
  input logic rst_n,
  truth_table_sweeper_if.slave s
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] H1 = 1, HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST = '1, I1 = 1;
  localparam logic [N_IN:0] C1 = 1;
  logic [1:0] st, nxt;
  logic [HW-1:0] hold;
  logic miss;
  assign miss = s.dut_f != EXP_TT[s.dut_in];
  always_comb begin
    nxt = st;
    if (st == IDLE) nxt = s.start && !s.abort ? DRIVE : IDLE;
    else if (s.abort) nxt = IDLE;
    else if (st == DRIVE) nxt = hold == HLAST ? SAMPLE : DRIVE;
    else if (st == SAMPLE) nxt = s.dut_in == LAST ? DONE : DRIVE;
    else nxt = IDLE;
  end
  // dut_in doubles as the vector index; the done pulse follows the DONE cycle so abort there can suppress it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      hold <= '0;
      s.dut_in <= '0;
      s.busy <= 1'b0;
      s.done <= 1'b0;
      s.tt <= '0;
      s.valid <= 1'b0;
      s.pass <= 1'b0;
      s.mismatch_cnt <= '0;
      s.first_fail <= '0;
      s.fail_valid <= 1'b0;
    end else begin
      st <= nxt;
      s.busy <= nxt == DRIVE || nxt == SAMPLE;
      s.done <= st == DONE && !s.abort;
      if (st == IDLE && nxt == DRIVE) begin
        s.dut_in <= '0;
        hold <= '0;
        s.tt <= '0;
        s.mismatch_cnt <= '0;
        s.fail_valid <= 1'b0;
        s.first_fail <= '0;
        s.valid <= 1'b0;
        s.pass <= 1'b0;
      end else if (st != IDLE && s.abort) begin
        s.dut_in <= '0;
        s.valid <= 1'b0;
        s.pass <= 1'b0;
      end else if (st == DRIVE) begin
        hold <= hold + H1;
      end else if (st == SAMPLE) begin
        s.tt[s.dut_in] <= s.dut_f;
        if (miss) s.mismatch_cnt <= s.mismatch_cnt + C1;
        if (miss && !s.fail_valid) begin
          s.first_fail <= s.dut_in;
          s.fail_valid <= 1'b1;
        end
        if (s.dut_in != LAST) begin
          s.dut_in <= s.dut_in + I1;
          hold <= '0;
        end
      end else if (st == DONE) begin
        s.valid <= 1'b1;
        s.pass <= s.mismatch_cnt == '0;
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: three sweepers against f = A ^ D with different expected tables
module tb_truth_table_sweeper;
  typedef struct {
    logic [15:0] tt;
    logic [4:0] cnt;
    logic [3:0] ff;
    logic fv;
    logic pass;
  } res_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  int nvec = 0, nmis = 0;
  res_t q[$];
  always #5 clk = ~clk;
  truth_table_sweeper_if #(.N_IN(4)) i0 ();
  truth_table_sweeper_if #(.N_IN(4)) i1 ();
  truth_table_sweeper_if #(.N_IN(4)) i2 ();
  assign i0.start = start;
  assign i1.start = start;
  assign i2.start = start;
  assign i0.abort = abort;
  assign i1.abort = abort;
  assign i2.abort = abort;
  assign i0.dut_f = i0.dut_in[3] ^ i0.dut_in[0];
  assign i1.dut_f = i1.dut_in[3] ^ i1.dut_in[0];
  assign i2.dut_f = i2.dut_in[3] ^ i2.dut_in[0];
  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(2), .EXP_TT(16'h55AA)) u0 (.clk(clk), .rst_n(rst_n), .s(i0.slave));
  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(2), .EXP_TT(16'h55AB)) u1 (.clk(clk), .rst_n(rst_n), .s(i1.slave));
  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(2), .EXP_TT(16'hAA55)) u2 (.clk(clk), .rst_n(rst_n), .s(i2.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  function automatic res_t model(input logic [15:0] e);
    res_t r;
    logic [3:0] v;
    logic f;
    r = '{tt: '0, cnt: '0, ff: '0, fv: 1'b0, pass: 1'b0};
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      f = v[3] ^ v[0];
      r.tt[i] = f;
      if (f != e[i]) begin
        if (!r.fv) begin
          r.fv = 1'b1;
          r.ff = v;
        end
        r.cnt = r.cnt + 5'd1;
      end
    end
    r.pass = r.cnt == 5'd0;
    return r;
  endfunction
  task automatic go(input bit push);
    if (push) begin
      q.push_back(model(16'h55AA));
      q.push_back(model(16'h55AB));
      q.push_back(model(16'hAA55));
    end
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic cmp(input string tag, input logic [15:0] tt, input logic [4:0] c,
                     input logic [3:0] ff, input logic fv, input logic ps, input logic vl);
    res_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, "_tt"}, tt, e.tt);
    chk({tag, "_cnt"}, c, e.cnt);
    chk({tag, "_fv"}, fv, e.fv);
    if (e.fv) chk({tag, "_ff"}, ff, e.ff);
    chk({tag, "_pass"}, ps, e.pass);
    chk({tag, "_valid"}, vl, 1);
  endtask
  task automatic check_all();
    cmp("u0", i0.tt, i0.mismatch_cnt, i0.first_fail, i0.fail_valid, i0.pass, i0.valid);
    cmp("u1", i1.tt, i1.mismatch_cnt, i1.first_fail, i1.fail_valid, i1.pass, i1.valid);
    cmp("u2", i2.tt, i2.mismatch_cnt, i2.first_fail, i2.fail_valid, i2.pass, i2.valid);
  endtask
  initial begin
    int n;
    bit seen;
    #12;
    chk("rst_dut_in", i0.dut_in, 0);
    chk("rst_busy", i0.busy, 0);
    chk("rst_done", i0.done, 0);
    chk("rst_valid", i0.valid, 0);
    chk("rst_tt", i0.tt, 0);
    rst_n = 1;
    tick();
    go(1);
    for (int j = 0; j < 48; j++) begin
      if (j % 3 == 0) chk($sformatf("vec%0d", j / 3), i0.dut_in, j / 3);
      if (j % 3 == 1) chk($sformatf("busy%0d", j / 3), i0.busy, 1);
      start = j == 15;
      tick();
    end
    chk("done_early", i0.done, 0);
    chk("busy_in_done", i0.busy, 0);
    start = 1;
    tick();
    start = 0;
    chk("done_at_49", i0.done, 1);
    if (i0.done) check_all();
    tick();
    chk("done_pulse_end", i0.done, 0);
    chk("start_in_done_ignored", i0.busy, 0);
    go(0);
    while (i0.dut_in != 4'd7 && n < 60) begin
      tick();
      n++;
    end
    chk("reach_vec7", i0.dut_in, 7);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_dut_in", i0.dut_in, 0);
    chk("abort_busy", i0.busy, 0);
    chk("abort_valid", i0.valid, 0);
    chk("abort_pass", i0.pass, 0);
    chk("abort_partial_tt", i0.tt, 16'h002A);
    chk("abort_partial_cnt", i2.mismatch_cnt, 7);
    seen = 0;
    repeat (55) begin
      seen |= i0.done;
      tick();
    end
    chk("abort_no_done", seen, 0);
    go(1);
    n = 0;
    while (!i0.done && n < 100) begin
      tick();
      n++;
    end
    chk("resweep_latency", n, 49);
    if (i0.done) check_all();
    tick();
    go(0);
    repeat (27) tick();
    chk("reach_vec9", i0.dut_in, 9);
    #2 rst_n = 0;
    #1;
    chk("arst_dut_in", i0.dut_in, 0);
    chk("arst_busy", i0.busy, 0);
    chk("arst_tt", i0.tt, 0);
    chk("arst_cnt", i2.mismatch_cnt, 0);
    chk("arst_valid", i0.valid, 0);
    chk("arst_fv", i2.fail_valid, 0);
    #2 rst_n = 1;
    tick();
    start = 1;
    abort = 1;
    tick();
    chk("start_abort_busy", i0.busy, 0);
    tick();
    start = 0;
    abort = 0;
    chk("start_abort_idle", i0.busy, 0);
    chk("start_abort_dut_in", i0.dut_in, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
